// File: rtl/proxy_mapper.sv
// Assigns faulty columns (reported after an STW pass) to a small pool of proxy PE
// units, drives the proxy routing selects and holds the mapping until cleared.
module proxy_mapper #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int NUM_PROXY = 2,
  localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int COL_W    = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int PRX_W    = (NUM_PROXY > 1) ? $clog2(NUM_PROXY) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       STW_complete,
  input  logic [COLS-1:0]            fault_detected,
  input  logic [COLS*ROW_W-1:0]      fpe_idx_sel_flat,
  input  logic                       remap_clear,
  output logic [COLS-1:0]            proxy_map_done,
  output logic [NUM_PROXY-1:0]       proxy_unit_valid,
  output logic [NUM_PROXY*COL_W-1:0] proxy_unit_col,
  output logic [NUM_PROXY*ROW_W-1:0] proxy_unit_row,
  output logic [COLS*PRX_W-1:0]      col_proxy_idx,
  output logic                       unrepairable,
  output logic                       map_busy
);

  // next_proxy must be able to reach NUM_PROXY to signal an exhausted pool
  localparam int NP_W = $clog2(NUM_PROXY + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ASSIGN = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic [COLS-1:0]            pending_q, pending_d;
  logic [COLS-1:0]            fault_q, fault_d;
  logic [COLS-1:0]            assigned_q, assigned_d;
  logic [COLS*ROW_W-1:0]      rows_q, rows_d;
  logic [NP_W-1:0]            next_proxy_q, next_proxy_d;
  logic [COLS-1:0]            done_q, done_d;
  logic [NUM_PROXY-1:0]       valid_q, valid_d;
  logic [NUM_PROXY*COL_W-1:0] unit_col_q, unit_col_d;
  logic [NUM_PROXY*ROW_W-1:0] unit_row_q, unit_row_d;
  logic [COLS*PRX_W-1:0]      cpi_q, cpi_d;
  logic                       unrep_q, unrep_d;

  logic                       sel_found;
  logic [COL_W-1:0]           sel_col;
  logic [COLS-1:0]            sel_mask;
  logic [PRX_W-1:0]           nidx;

  assign nidx = next_proxy_q[PRX_W-1:0];

  // Lowest-index pending column wins
  always_comb begin
    sel_found = 1'b0;
    sel_col   = '0;
    sel_mask  = '0;
    for (int c = 0; c < COLS; c++) begin
      if (!sel_found && pending_q[c]) begin
        sel_found   = 1'b1;
        sel_col     = COL_W'(c);
        sel_mask[c] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    fault_d      = fault_q;
    assigned_d   = assigned_q;
    rows_d       = rows_q;
    next_proxy_d = next_proxy_q;
    done_d       = done_q;
    valid_d      = valid_q;
    unit_col_d   = unit_col_q;
    unit_row_d   = unit_row_q;
    cpi_d        = cpi_q;
    unrep_d      = unrep_q;

    case (state_q)
      S_IDLE: begin
        if (STW_complete) begin
          pending_d = fault_detected;
          fault_d   = fault_detected;
          rows_d    = fpe_idx_sel_flat;
          state_d   = S_ASSIGN;
        end
      end
      S_ASSIGN: begin
        if (!stall) begin
          if (!sel_found) begin
            state_d = S_DONE;
            done_d  = ~fault_q | assigned_q;
          end else if (next_proxy_q < NP_W'(NUM_PROXY)) begin
            unit_col_d[nidx*COL_W +: COL_W]   = sel_col;
            unit_row_d[nidx*ROW_W +: ROW_W]   = rows_q[sel_col*ROW_W +: ROW_W];
            valid_d[nidx]                     = 1'b1;
            cpi_d[sel_col*PRX_W +: PRX_W]     = nidx;
            pending_d                         = pending_q & ~sel_mask;
            assigned_d                        = assigned_q | sel_mask;
            next_proxy_d                      = next_proxy_q + 1'b1;
            if (pending_d == '0) begin
              state_d = S_DONE;
              done_d  = ~fault_q | assigned_d;
            end
          end else begin
            // Pool exhausted: remaining faulty columns never get proxy_map_done
            unrep_d   = 1'b1;
            pending_d = '0;
            state_d   = S_DONE;
            done_d    = ~fault_q | assigned_q;
          end
        end
      end
      S_DONE: begin
      end
      default: state_d = S_IDLE;
    endcase
  end

  // remap_clear behaves exactly like reset and ignores stall
  always_ff @(posedge clk) begin
    if (rst || remap_clear) begin
      state_q      <= S_IDLE;
      pending_q    <= '0;
      fault_q      <= '0;
      assigned_q   <= '0;
      rows_q       <= '0;
      next_proxy_q <= '0;
      done_q       <= '0;
      valid_q      <= '0;
      unit_col_q   <= '0;
      unit_row_q   <= '0;
      cpi_q        <= '0;
      unrep_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      fault_q      <= fault_d;
      assigned_q   <= assigned_d;
      rows_q       <= rows_d;
      next_proxy_q <= next_proxy_d;
      done_q       <= done_d;
      valid_q      <= valid_d;
      unit_col_q   <= unit_col_d;
      unit_row_q   <= unit_row_d;
      cpi_q        <= cpi_d;
      unrep_q      <= unrep_d;
    end
  end

  assign proxy_map_done   = done_q;
  assign proxy_unit_valid = valid_q;
  assign proxy_unit_col   = unit_col_q;
  assign proxy_unit_row   = unit_row_q;
  assign col_proxy_idx    = cpi_q;
  assign unrepairable     = unrep_q;
  assign map_busy         = (state_q == S_ASSIGN);

endmodule

// File: tb/tb_proxy_mapper.sv
// Directed bench for proxy_mapper (defaults ROWS=4, COLS=4, NUM_PROXY=2); expected
// mappings are queued at stimulus time and compared once the mapper leaves ASSIGN.
module tb_proxy_mapper;

  logic       clk;
  logic       rst;
  logic       stall;
  logic       STW_complete;
  logic [3:0] fault_detected;
  logic [7:0] fpe_idx_sel_flat;
  logic       remap_clear;
  logic [3:0] proxy_map_done;
  logic [1:0] proxy_unit_valid;
  logic [3:0] proxy_unit_col;
  logic [3:0] proxy_unit_row;
  logic [3:0] col_proxy_idx;
  logic       unrepairable;
  logic       map_busy;

  typedef struct {
    logic [3:0] done;
    logic [1:0] valid;
    logic [3:0] ucol;
    logic [3:0] urow;
    logic [3:0] cpi;
    logic       unrep;
    int         lat;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;
  int   lastLat = 0;

  proxy_mapper dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .STW_complete     (STW_complete),
    .fault_detected   (fault_detected),
    .fpe_idx_sel_flat (fpe_idx_sel_flat),
    .remap_clear      (remap_clear),
    .proxy_map_done   (proxy_map_done),
    .proxy_unit_valid (proxy_unit_valid),
    .proxy_unit_col   (proxy_unit_col),
    .proxy_unit_row   (proxy_unit_row),
    .col_proxy_idx    (col_proxy_idx),
    .unrepairable     (unrepairable),
    .map_busy         (map_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    check({tag, ".done"},   32'(proxy_map_done),   32'h0);
    check({tag, ".valid"},  32'(proxy_unit_valid), 32'h0);
    check({tag, ".ucol"},   32'(proxy_unit_col),   32'h0);
    check({tag, ".urow"},   32'(proxy_unit_row),   32'h0);
    check({tag, ".cpi"},    32'(col_proxy_idx),    32'h0);
    check({tag, ".unrep"},  32'(unrepairable),     32'h0);
    check({tag, ".busy"},   32'(map_busy),         32'h0);
  endtask

  task automatic checkMapping(input string tag, input exp_t e);
    check({tag, ".done"},  32'(proxy_map_done),   32'(e.done));
    check({tag, ".valid"}, 32'(proxy_unit_valid), 32'(e.valid));
    check({tag, ".ucol"},  32'(proxy_unit_col),   32'(e.ucol));
    check({tag, ".urow"},  32'(proxy_unit_row),   32'(e.urow));
    check({tag, ".cpi"},   32'(col_proxy_idx),    32'(e.cpi));
    check({tag, ".unrep"}, 32'(unrepairable),     32'(e.unrep));
  endtask

  // Pulses STW_complete, then scrambles the row inputs (they must already be latched)
  // and runs until map_busy drops, stalling edges t(stallAt+1)..t(stallAt+stallLen)
  task automatic applyStimulus(input string tag, input logic [3:0] fault, input logic [7:0] rows,
                               input int stallAt, input int stallLen, input exp_t e);
    int cycles;
    expQ.push_back(e);
    @(negedge clk);
    STW_complete     = 1'b1;
    fault_detected   = fault;
    fpe_idx_sel_flat = rows;
    @(negedge clk);
    STW_complete     = 1'b0;
    fault_detected   = ~fault;
    fpe_idx_sel_flat = ~rows;
    check({tag, ".busyStart"}, 32'(map_busy), 32'h1);
    cycles = 0;
    while (cycles < 30) begin
      stall = (cycles >= stallAt) && (cycles < stallAt + stallLen);
      @(negedge clk);
      cycles++;
      if (!map_busy) break;
      check({tag, ".doneEarly"}, 32'(proxy_map_done), 32'h0);
    end
    stall   = 1'b0;
    lastLat = cycles;
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (expQ.size() == 0) begin
      check({tag, ".queueEmpty"}, 32'h0, 32'h1);
    end else begin
      e = expQ.pop_front();
      check({tag, ".latency"}, 32'(lastLat), 32'(e.lat));
      checkMapping(tag, e);
    end
  endtask

  exp_t e1, e2, e3, e4, e5, e6;

  initial begin
    // Expected values derived by hand from the assignment rules (lowest column first)
    e1 = '{done: 4'b1111, valid: 2'b00, ucol: 4'h0, urow: 4'h0, cpi: 4'h0, unrep: 1'b0, lat: 1};
    e2 = '{done: 4'b1111, valid: 2'b01, ucol: 4'b0010, urow: 4'b0011, cpi: 4'b0000, unrep: 1'b0, lat: 1};
    e3 = '{done: 4'b1111, valid: 2'b11, ucol: 4'b1100, urow: 4'b1001, cpi: 4'b1000, unrep: 1'b0, lat: 2};
    e4 = '{done: 4'b1011, valid: 2'b11, ucol: 4'b0100, urow: 4'b0100, cpi: 4'b0010, unrep: 1'b1, lat: 3};
    e5 = e3;
    e5.lat = 5;
    e6 = '{done: 4'b1111, valid: 2'b01, ucol: 4'b0001, urow: 4'b0010, cpi: 4'b0000, unrep: 1'b0, lat: 1};

    rst = 1'b1;
    stall = 1'b0;
    STW_complete = 1'b0;
    fault_detected = 4'h0;
    fpe_idx_sel_flat = 8'h0;
    remap_clear = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkIdle("reset");

    applyStimulus("noFault", 4'b0000, 8'h79, 99, 0, e1);
    checkOutput("noFault");
    remap_clear = 1'b1;
    @(negedge clk);
    remap_clear = 1'b0;

    applyStimulus("oneFault", 4'b0100, 8'h79, 99, 0, e2);
    checkOutput("oneFault");
    remap_clear = 1'b1;
    @(negedge clk);
    remap_clear = 1'b0;

    applyStimulus("twoFault", 4'b1001, 8'hB1, 99, 0, e3);
    checkOutput("twoFault");
    remap_clear = 1'b1;
    @(negedge clk);
    remap_clear = 1'b0;

    applyStimulus("overflow", 4'b0111, 8'hE4, 99, 0, e4);
    checkOutput("overflow");
    remap_clear = 1'b1;
    @(negedge clk);
    remap_clear = 1'b0;

    applyStimulus("stalled", 4'b1001, 8'hB1, 1, 3, e5);
    checkOutput("stalled");

    // Mapping must stay put in DONE even with a new STW pulse
    STW_complete = 1'b1;
    fault_detected = 4'b1111;
    fpe_idx_sel_flat = 8'hFF;
    @(negedge clk);
    STW_complete = 1'b0;
    @(negedge clk);
    checkMapping("holdDone", e3);

    remap_clear = 1'b1;
    @(negedge clk);
    remap_clear = 1'b0;
    checkIdle("clearDone");

    // Clear mid-ASSIGN, colliding with an STW pulse that must lose
    STW_complete = 1'b1;
    fault_detected = 4'b1001;
    fpe_idx_sel_flat = 8'hB1;
    @(negedge clk);
    STW_complete = 1'b0;
    @(negedge clk);
    check("midAssign.valid", 32'(proxy_unit_valid), 32'h1);
    remap_clear = 1'b1;
    STW_complete = 1'b1;
    fault_detected = 4'b1111;
    @(negedge clk);
    remap_clear = 1'b0;
    STW_complete = 1'b0;
    checkIdle("clearAssign");

    applyStimulus("afterClear", 4'b0010, 8'h1B, 99, 0, e6);
    checkOutput("afterClear");

    // Reset mid-ASSIGN
    remap_clear = 1'b1;
    @(negedge clk);
    remap_clear = 1'b0;
    STW_complete = 1'b1;
    fault_detected = 4'b0111;
    fpe_idx_sel_flat = 8'hE4;
    @(negedge clk);
    STW_complete = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkIdle("rstAssign");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/proxy_mapper.md
Name: proxy_mapper

Overview:
- Array-level responder to the per-column proxy controllers.
- After a stationary-weight test (STW) pass, it takes each column's fault flag and faulty-PE row index and assigns each faulty column one of a small pool of proxy PE units.
- It drives the proxy-unit routing selects and raises the per-column proxy_map_done handshake that the column controllers wait on before loading and computing with their proxy.
- It holds the mapping until it is explicitly cleared for the next weight load.

Parameters:
ROWS, 4, rows per column; ROW_W = $clog2(ROWS)
COLS, 4, columns served; COL_W = $clog2(COLS)
NUM_PROXY, 2, proxy units in pool; PRX_W = max(1, $clog2(NUM_PROXY))

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
stall  in  1  freezes assignment progress
STW_complete  in  1  STW pass finished; fault inputs valid this cycle
fault_detected  in  COLS  per-column fault flag
fpe_idx_sel_flat  in  COLS*ROW_W  per-column faulty row index; column c occupies bits [c*ROW_W +: ROW_W]
remap_clear  in  1  discard mapping (new weights coming)
proxy_map_done  out  COLS  per-column mapping complete
proxy_unit_valid  out  NUM_PROXY  proxy unit p is assigned
proxy_unit_col  out  NUM_PROXY*COL_W  column served by unit p
proxy_unit_row  out  NUM_PROXY*ROW_W  faulty row replaced by unit p
col_proxy_idx  out  COLS*PRX_W  unit assigned to column c
unrepairable  out  1  more faulty columns than proxy units
map_busy  out  1  high while in ASSIGN

Behaviour:
- Reset: clk/rst as decided. Every output and internal register resets to 0; state goes to IDLE.
- All outputs are registered, except map_busy, which is decoded from state.
- IDLE:
  - On STW_complete=1, latch fault_detected into the pending mask and latch all row indices. Go to ASSIGN.
  - Other inputs are ignored.
- ASSIGN, one column per non-stalled cycle:
  - pending==0 on entry: go to DONE.
  - Otherwise take the lowest-index pending column c.
  - If next_proxy < NUM_PROXY: write unit next_proxy with col = c, row = latched row[c], valid = 1. Set col_proxy_idx[c] = next_proxy. Clear pending[c] and increment next_proxy. If pending becomes 0, go to DONE on the same edge.
  - If no unit is free: set unrepairable = 1, clear pending, go to DONE.
  - stall=1 holds all state and registers.
- DONE:
  - proxy_map_done[c] = 1 for every column that is fault-free or assigned.
  - Faulty but unassigned columns stay 0.
  - The mapping is held stable. STW_complete is ignored.
- Latency:
  - k faulty columns (k ≤ NUM_PROXY) with STW_complete at edge t0: assignments land at edges t1..tk, and proxy_map_done is visible after edge tk.
  - k = 0: proxy_map_done is visible after t1.
  - Each stalled cycle adds one cycle.
- remap_clear:
  - In any state, it returns all outputs to reset values and goes to IDLE on the next edge.
  - It is not gated by stall.
  - It wins over a simultaneous STW_complete.
- rst mid-ASSIGN behaves like remap_clear.
- Row indices are latched at STW_complete. Later changes to fpe_idx_sel_flat do not affect the mapping.

Test Plan:
1. fault_detected=0000, STW_complete pulse → after 1 edge proxy_map_done=1111, proxy_unit_valid=00, unrepairable=0, map_busy high for 1 cycle.
2. fault on col2, row3 → unit0 col=2, row=3; proxy_unit_valid=01; col_proxy_idx[2]=0; proxy_map_done=1111 after edge t1.
3. faults on col0 (row1) and col3 (row2) → unit0→col0/row1, unit1→col3/row2; proxy_map_done=1111 after edge t2; proxy_unit_valid=11.
4. faults on cols 0, 1, 2 (rows 0, 1, 2), NUM_PROXY=2 → units assigned to cols 0 and 1; unrepairable=1; proxy_map_done=1011 (col2 held 0).
5. Scenario 3 with stall=1 for 3 cycles after t1 → proxy_map_done delayed exactly 3 cycles; final mapping identical.
6. remap_clear in DONE, and separately mid-ASSIGN → all outputs 0 next cycle and state IDLE. A following STW_complete with col1 row2 faulty maps unit0→col1/row2.
